bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It turns binary values such as the PC and register fields into packed 4-bit decimal digits. Those digits drive the 7-segment digit decoders directly. Codes 0-9 are digits; 4'hF means blank, since the decoders show nothing for codes above 9.

---
 rtl/bin_to_bcd_seq.sv | 148 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3), one
// input bit per clock. Results drive 7-segment digit decoders directly; code
// 4'hF blanks a digit.
// Optional build macro: BCD_LEADING_BLANK_EN -- blank leading zero digits
// (digit 0 is never blanked). Without it, leading zeros stay 4'h0.
module bin_to_bcd_seq #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    // Add 3 to every digit that is 5 or more; digits are independent (no carry).
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        r = a;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Turn the finished accumulator into display codes: blank everything on
    // overflow, and optionally blank leading zero digits above digit 0.
    function automatic logic [BCD_W-1:0] format_result(input logic [BCD_W-1:0] a,
                                                       input logic ovf);
        logic [BCD_W-1:0] r;
        r = a;
        if (ovf) begin
            r = '1;
        end
`ifdef BCD_LEADING_BLANK_EN
        else begin : blank_lead
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (r[4*i +: 4] == 4'd0)) begin
                    r[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic                ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic [BCD_W-1:0]    adj;
    assign adj = add3(acc_q);

    // Next-state logic: accept a start in IDLE, run one double-dabble step per clock in SHIFT.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    acc_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(IN_WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // {adj, shift_q} << 1; the bit leaving the MS digit marks overflow
                acc_d     = {adj[BCD_W-2:0], shift_q[IN_WIDTH-1]};
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = format_result(acc_d, ovf_acc_d);
                    ovf_d   = ovf_acc_d;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion and clears the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: a 3-digit and a 2-digit instance, directed
// vectors pushed into per-instance expectation queues, monitors compare on done.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start3 = 1'b0, start2 = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q3[$];
    exp_t q2[$];
    logic prev3 = 1'b0, prev2 = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
    );

    bin_to_bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference for the sweep, built from division rather than shifting.
    function automatic logic [11:0] model_bcd(input int v);
        logic [11:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef BCD_LEADING_BLANK_EN
        begin : blank_lead
            bit lead;
            lead = 1'b1;
            for (int i = 2; i >= 1; i--) begin
                if (lead && (r[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    // Wait for done on the selected instance; latency counts edges after the accept edge.
    task automatic wait_done(input bit sel2, input string name);
        int   cycles;
        logic got;
        logic gap;
        cycles = 0;
        gap    = 1'b0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            got = sel2 ? done2 : done3;
            if (!got && !(sel2 ? busy2 : busy3)) gap = 1'b1;
        end
        check({name, "_latency"}, cycles, 8);
        check({name, "_busy_gap"}, {31'd0, gap}, 0);
        check({name, "_busy_at_done"}, {31'd0, sel2 ? busy2 : busy3}, 0);
    endtask

    // One conversion: drive start for one cycle, push the expectation, wait for done.
    task automatic convert(input bit sel2, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic exp_ovf, input string name);
        exp_t e;
        e.bcd  = exp_bcd;
        e.ovf  = exp_ovf;
        bin_in = v;
        if (sel2) begin start2 = 1'b1; q2.push_back(e); end
        else      begin start3 = 1'b1; q3.push_back(e); end
        @(posedge clk); #1;
        start2 = 1'b0;
        start3 = 1'b0;
        bin_in = ~v;  // changes during SHIFT must be ignored
        check({name, "_busy"}, {31'd0, sel2 ? busy2 : busy3}, 1);
        wait_done(sel2, name);
    endtask

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done3) begin
            check("done3_single_cycle", {31'd0, prev3}, 0);
            if (q3.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done3_unexpected: got done with bcd %0h, required no done", bcd3);
            end else begin
                e = q3.pop_front();
                check("bcd3", {20'd0, bcd3}, {20'd0, e.bcd});
                check("ovf3", {31'd0, ovf3}, {31'd0, e.ovf});
            end
        end
        prev3 = done3;
    end

    // Monitor for the 2-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done2) begin
            check("done2_single_cycle", {31'd0, prev2}, 0);
            if (q2.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done2_unexpected: got done with bcd %0h, required no done", bcd2);
            end else begin
                e = q2.pop_front();
                check("bcd2", {24'd0, bcd2}, {24'd0, e.bcd[7:0]});
                check("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
            end
        end
        prev2 = done2;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   ndone;
        // Reset state
        #1;
        check("rst_busy", {31'd0, busy3}, 0);
        check("rst_done", {31'd0, done3}, 0);
        check("rst_bcd", {20'd0, bcd3}, 0);
        check("rst_ovf", {31'd0, ovf3}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Full-scale value
        convert(0, 8'd255, 12'h255, 1'b0, "t1_255");

        // Back-to-back conversions
`ifdef BCD_LEADING_BLANK_EN
        convert(0, 8'd99, 12'hF99, 1'b0, "t2_99");
        convert(0, 8'd0,  12'hFF0, 1'b0, "t2_0");
`else
        convert(0, 8'd99, 12'h099, 1'b0, "t2_99");
        convert(0, 8'd0,  12'h000, 1'b0, "t2_0");
`endif

        // Two-digit instance: overflow then recovery
        convert(1, 8'd100, 12'h0FF, 1'b1, "t3_100");
        convert(1, 8'd42,  12'h042, 1'b0, "t3_42");
        convert(1, 8'd99,  12'h099, 1'b0, "t3_99");
`ifdef BCD_LEADING_BLANK_EN
        convert(1, 8'd5,   12'h0F5, 1'b0, "t3_5");
`else
        convert(1, 8'd5,   12'h005, 1'b0, "t3_5");
`endif
        convert(1, 8'd255, 12'h0FF, 1'b1, "t3_255");

        // start held high; bin_in changes during SHIFT
        bin_in = 8'd200;
        start3 = 1'b1;
        e.bcd = 12'h200; e.ovf = 1'b0; q3.push_back(e);
        @(posedge clk); #1;
        bin_in = 8'd7;
`ifdef BCD_LEADING_BLANK_EN
        e.bcd = 12'hFF7;
`else
        e.bcd = 12'h007;
`endif
        q3.push_back(e);
        wait_done(0, "t4_first");
        @(posedge clk); #1;
        check("t4_second_accept", {31'd0, busy3}, 1);
        bin_in = 8'd55;
        start3 = 1'b0;
        wait_done(0, "t4_second");

        // Asynchronous reset mid-conversion
        bin_in = 8'd123;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_bcd3", {20'd0, bcd3}, 0);
        check("t5_rst_busy3", {31'd0, busy3}, 0);
        check("t5_rst_done3", {31'd0, done3}, 0);
        check("t5_rst_bcd2", {24'd0, bcd2}, 0);
        check("t5_rst_ovf2", {31'd0, ovf2}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done3) ndone++;
        end
        check("t5_no_done", ndone, 0);
        convert(0, 8'd128, 12'h128, 1'b0, "t5_128");

        // Exhaustive sweep on the 3-digit instance
        for (int v = 0; v < 256; v++) begin
            convert(0, 8'(v), model_bcd(v), 1'b0, "t6_sweep");
        end

        repeat (3) @(posedge clk);
        #1;
        check("q3_drained", q3.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
